// File: rtl/aesl_deadlock_monitor.sv
// Wait-for-graph deadlock monitor for N dataflow processes: snapshots blocking state, then searches for a cycle.
// Optional global-stall timeout enabled by defining AESL_DL_STALL_TIMEOUT_EN.
module aesl_deadlock_monitor #(
    parameter int N           = 3,
    parameter int THRESH      = 16,
    parameter int STALL_LIMIT = 1024,
    parameter int OW          = (N > 1) ? $clog2(N) : 1
) (
    input  logic            dl_clock,
    input  logic            dl_reset,
    input  logic            all_finish,
    input  logic [N-1:0]    proc_blk,
    input  logic [N*N-1:0]  proc_dep,
    output logic            dl_detect,
    output logic [OW-1:0]   dl_origin,
    output logic [N-1:0]    dl_mask,
    output logic            dl_busy,
    output logic            dl_stall
);

    typedef enum logic [1:0] {S_IDLE, S_ARM, S_SEARCH, S_REPORT} state_t;
    typedef enum logic {PH_LOAD, PH_PROP} phase_t;

    localparam int              CW         = $clog2(THRESH + 1);
    localparam logic [CW-1:0]   CNT_THRESH = CW'(THRESH);
    localparam logic [OW-1:0]   LAST       = OW'(N - 1);

    state_t          state_q, state_d;
    phase_t          phase_q, phase_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [N-1:0]    blk_s_q, blk_s_d;
    logic [N*N-1:0]  dep_s_q, dep_s_d;
    logic [OW-1:0]   o_q, o_d;
    logic [OW-1:0]   step_q, step_d;
    logic [N-1:0]    reach_q, reach_d;
    logic            detect_q, detect_d;
    logic [OW-1:0]   origin_q, origin_d;
    logic [N-1:0]    mask_q, mask_d;

    logic            stable;
    logic            skip;
    logic [N-1:0]    reach_or;
    logic [N-1:0]    reach_next;

    // One propagation step: add every blocked process that a current member waits on.
    always_comb begin
        reach_or = reach_q;
        for (int j = 0; j < N; j++) begin
            if (reach_q[j]) begin
                reach_or = reach_or | dep_s_q[j*N +: N];
            end
        end
        reach_next = reach_or & blk_s_q;
    end

    // NOTE: every signal assigned here gets a default first, so no path leaves one unassigned (no latches).
    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        cnt_d    = cnt_q;
        blk_s_d  = blk_s_q;
        dep_s_d  = dep_s_q;
        o_d      = o_q;
        step_d   = step_q;
        reach_d  = reach_q;
        detect_d = detect_q;
        origin_d = origin_q;
        mask_d   = mask_q;
        skip     = 1'b0;
        stable   = (proc_blk == blk_s_q) && (proc_dep == dep_s_q);

        case (state_q)
            S_IDLE: begin
                if (!all_finish && (proc_blk != '0)) begin
                    state_d = S_ARM;
                    cnt_d   = CW'(1);
                    blk_s_d = proc_blk;
                    dep_s_d = proc_dep;
                end
            end
            S_ARM: begin
                if (all_finish || !stable) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_THRESH) begin
                    state_d = S_SEARCH;
                    o_d     = '0;
                    phase_d = PH_LOAD;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_SEARCH: begin
                // Abort outranks every search transition evaluated below.
                if (all_finish || !stable) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    if (phase_q == PH_LOAD) begin
                        if (!blk_s_q[o_q]) begin
                            skip = 1'b1;
                        end else begin
                            reach_d = dep_s_q[o_q*N +: N] & blk_s_q;
                            step_d  = '0;
                            phase_d = PH_PROP;
                        end
                    end else begin
                        if (reach_q[o_q]) begin
                            state_d  = S_REPORT;
                            detect_d = 1'b1;
                            origin_d = o_q;
                            mask_d   = reach_q;
                        end else if ((reach_next == reach_q) || (step_q == LAST)) begin
                            skip = 1'b1;
                        end else begin
                            reach_d = reach_next;
                            step_d  = step_q + OW'(1);
                        end
                    end

                    if (skip) begin
                        if (o_q == LAST) begin
                            state_d = S_IDLE;
                            cnt_d   = '0;
                        end else begin
                            o_d     = o_q + OW'(1);
                            phase_d = PH_LOAD;
                        end
                    end
                end
            end
            default: ;  // S_REPORT holds everything until reset.
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together on the edge.
    always_ff @(posedge dl_clock or negedge dl_reset) begin
        if (!dl_reset) begin
            state_q  <= S_IDLE;
            phase_q  <= PH_LOAD;
            cnt_q    <= '0;
            blk_s_q  <= '0;
            dep_s_q  <= '0;
            o_q      <= '0;
            step_q   <= '0;
            reach_q  <= '0;
            detect_q <= 1'b0;
            origin_q <= '0;
            mask_q   <= '0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            cnt_q    <= cnt_d;
            blk_s_q  <= blk_s_d;
            dep_s_q  <= dep_s_d;
            o_q      <= o_d;
            step_q   <= step_d;
            reach_q  <= reach_d;
            detect_q <= detect_d;
            origin_q <= origin_d;
            mask_q   <= mask_d;
        end
    end

    assign dl_detect = detect_q;
    assign dl_origin = origin_q;
    assign dl_mask   = mask_q;
    assign dl_busy   = (state_q == S_ARM) || (state_q == S_SEARCH);

`ifdef AESL_DL_STALL_TIMEOUT_EN
    localparam int             SCW       = $clog2(STALL_LIMIT + 1);
    localparam logic [SCW-1:0] STALL_MAX = SCW'(STALL_LIMIT);

    logic [SCW-1:0] stall_cnt_q, stall_cnt_d;
    logic           stall_q, stall_d;

    // Saturating all-blocked counter, independent of the search FSM.
    always_comb begin
        stall_cnt_d = '0;
        if (!all_finish && (&proc_blk)) begin
            stall_cnt_d = (stall_cnt_q == STALL_MAX) ? stall_cnt_q : stall_cnt_q + SCW'(1);
        end
        stall_d = stall_q | (stall_cnt_d == STALL_MAX);
    end

    always_ff @(posedge dl_clock or negedge dl_reset) begin
        if (!dl_reset) begin
            stall_cnt_q <= '0;
            stall_q     <= 1'b0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            stall_q     <= stall_d;
        end
    end

    assign dl_stall = stall_q;
`else
    // Timeout absent: the constant-false term only keeps STALL_LIMIT referenced.
    assign dl_stall = 1'b0 & (STALL_LIMIT == 0);
`endif

endmodule
